// File: rtl/memory_bus_dma.sv
// Block-copy bus initiator: moves COUNT words from src to dst over the shared CPU memory bus,
// one read/write pair per word, yielding the bus whenever the arbiter withdraws grant.
module memory_bus_dma #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned COUNT_WIDTH  = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            src_address,
  input  logic [15:0]            dst_address,
  input  logic [COUNT_WIDTH-1:0] count,
  output logic                   busy,
  output logic                   done,
  output logic                   bus_request,
  input  logic                   bus_grant,
  output logic [15:0]            address,
  output logic [31:0]            bus_data_out,
  input  logic [31:0]            bus_data_in,
  output logic [3:0]             write_mask,
  output logic                   bus_enable,
  output logic                   write_enable
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRead,
    StWait,
    StWrite,
    StDone
  } state_e;

  localparam logic [2:0] WaitLast = 3'(READ_LATENCY - 1);

  state_e                 state_q, state_d;
  logic [15:0]            src_q, src_d;
  logic [15:0]            dst_q, dst_d;
  logic [15:0]            addr_q;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic [31:0]            buf_q, buf_d;
  logic [2:0]             wait_q, wait_d;

  // Byte-offset bits are dropped; transfers are always word aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{src_address[1:0], dst_address[1:0]};

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    rem_d        = rem_q;
    buf_d        = buf_q;
    wait_d       = wait_q;
    address      = addr_q;
    bus_data_out = '0;
    write_mask   = 4'b0000;
    bus_enable   = 1'b0;
    write_enable = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d  = {src_address[15:2], 2'b00};
          dst_d  = {dst_address[15:2], 2'b00};
          rem_d  = count;
          wait_d = '0;
          // A grant already present when starting lets the first read go out immediately.
          if (count == '0) begin
            state_d = StDone;
          end else if (bus_grant) begin
            state_d = StRead;
          end else begin
            state_d = StReq;
          end
        end
      end

      StReq: begin
        if (bus_grant) begin
          state_d = StRead;
        end
      end

      StRead: begin
        if (!bus_grant) begin
          state_d = StReq;
        end else begin
          address    = src_q;
          bus_enable = 1'b1;
          wait_d     = '0;
          state_d    = StWait;
        end
      end

      StWait: begin
        if (!bus_grant) begin
          state_d = StReq;
        end else begin
          address    = src_q;
          bus_enable = 1'b1;
          if (wait_q == WaitLast) begin
            buf_d   = bus_data_in;
            state_d = StWrite;
          end else begin
            wait_d = wait_q + 3'd1;
          end
        end
      end

      StWrite: begin
        if (!bus_grant) begin
          state_d = StReq;
        end else begin
          address      = dst_q;
          bus_data_out = buf_q;
          write_mask   = 4'b1111;
          bus_enable   = 1'b1;
          write_enable = 1'b1;
          src_d        = src_q + 16'd4;
          dst_d        = dst_q + 16'd4;
          rem_d        = rem_q - COUNT_WIDTH'(1);
          state_d      = (rem_q == COUNT_WIDTH'(1)) ? StDone : StRead;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy        = (state_q == StReq) || (state_q == StRead) ||
                       (state_q == StWait) || (state_q == StWrite);
  assign bus_request = busy;
  assign done        = (state_q == StDone);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      addr_q  <= address;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_memory_bus_dma.sv
// Self-checking bench for memory_bus_dma: a word-addressed RAM with one-cycle read latency,
// a bus activity monitor, and a sequential copy model that predicts every write.
module tb_memory_bus_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] src_address;
  logic [15:0] dst_address;
  logic [10:0] count;
  logic        busy;
  logic        done;
  logic        bus_request;
  logic        bus_grant;
  logic [15:0] address;
  logic [31:0] bus_data_out;
  logic [31:0] bus_data_in;
  logic [3:0]  write_mask;
  logic        bus_enable;
  logic        write_enable;

  memory_bus_dma #(
    .READ_LATENCY (1),
    .COUNT_WIDTH  (11)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .src_address  (src_address),
    .dst_address  (dst_address),
    .count        (count),
    .busy         (busy),
    .done         (done),
    .bus_request  (bus_request),
    .bus_grant    (bus_grant),
    .address      (address),
    .bus_data_out (bus_data_out),
    .bus_data_in  (bus_data_in),
    .write_mask   (write_mask),
    .bus_enable   (bus_enable),
    .write_enable (write_enable)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    if (i < 4) return 32'h11111111 * 32'(i + 1);
    return (32'(i) * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  // Bus monitor and RAM; sole writer of mem and of the activity logs.
  logic [31:0] mem [16384];
  logic [15:0] rd_log[$];
  logic [15:0] wr_log_a[$];
  logic [31:0] wr_log_d[$];
  int          req_cnt = 0, en_cnt = 0, we_cnt = 0, busy_cnt = 0, done_cnt = 0, done_cyc = 0;
  int          nogrant_strobe = 0, mask_bad = 0;
  logic        pend_v = 1'b0;
  logic [31:0] pend = '0;

  initial begin
    logic        re;
    logic        prev_re;
    logic [15:0] prev_a;
    prev_re = 1'b0;
    prev_a  = '0;
    for (int i = 0; i < 16384; i++) mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      re = bus_enable && !write_enable;
      if (re && !(prev_re && prev_a == address)) rd_log.push_back(address);
      pend_v  = re;
      pend    = mem[address[15:2]];
      prev_re = re;
      prev_a  = address;
      if (bus_enable && write_enable) begin
        wr_log_a.push_back(address);
        wr_log_d.push_back(bus_data_out);
        if (write_mask != 4'hF) mask_bad++;
        mem[address[15:2]] = bus_data_out;
      end
      if (!bus_grant && (bus_enable || write_enable)) nogrant_strobe++;
      if (bus_request) req_cnt++;
      if (bus_enable) en_cnt++;
      if (write_enable) we_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Read data appears one cycle after the address is presented; garbage otherwise.
  always @(posedge clk) begin
    #1;
    bus_data_in = pend_v ? pend : 32'hDEADBEEF;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: word-by-word sequential copy over a 64 KiB byte space with 16-bit wrap.
  logic [31:0] refm [16384];
  logic [15:0] exp_a[$];
  logic [31:0] exp_d[$];
  int          s_cyc;

  task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input int n);
    logic [15:0] sa, da;
    sa = {s[15:2], 2'b00};
    da = {d[15:2], 2'b00};
    exp_a.delete();
    exp_d.delete();
    for (int i = 0; i < n; i++) begin
      refm[da[15:2]] = refm[sa[15:2]];
      exp_a.push_back(da);
      exp_d.push_back(refm[da[15:2]]);
      sa = sa + 16'd4;
      da = da + 16'd4;
    end
  endtask

  task automatic do_start(input logic [15:0] s, input logic [15:0] d, input int n);
    start       = 1'b1;
    src_address = s;
    dst_address = d;
    count       = 11'(n);
    s_cyc       = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int limit);
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (done_cnt != d0 || k >= limit) break;
      k++;
      @(posedge clk);
      #1;
    end
    if (done_cnt == d0) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    tick(1);
  endtask

  task automatic check_writes(input string tag, input int w0);
    int nw;
    nw = wr_log_a.size() - w0;
    check_eq({tag, "_nwrites"}, nw, exp_a.size());
    for (int i = 0; i < nw && i < exp_a.size(); i++) begin
      check_eq($sformatf("%s_waddr%0d", tag, i), wr_log_a[w0 + i], exp_a[i]);
      check_eq($sformatf("%s_wdata%0d", tag, i), wr_log_d[w0 + i], exp_d[i]);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_done"}, done, 1'b0);
    check_eq({tag, "_req"}, bus_request, 1'b0);
    check_eq({tag, "_addr"}, address, 16'h0);
    check_eq({tag, "_wdata"}, bus_data_out, 32'h0);
    check_eq({tag, "_mask"}, write_mask, 4'h0);
    check_eq({tag, "_en"}, bus_enable, 1'b0);
    check_eq({tag, "_we"}, write_enable, 1'b0);
  endtask

  initial begin
    int w0, d0, b0, r0, q0, e0, x0, nw, bad;
    logic [15:0] rs, rd;
    int rn, k;

    reset       = 1'b1;
    start       = 1'b0;
    src_address = '0;
    dst_address = '0;
    count       = '0;
    bus_grant   = 1'b1;
    for (int i = 0; i < 16384; i++) refm[i] = init_word(i);
    tick(2);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    tick(2);

    // Basic copy: 4 words, grant held, 3 cycles per word.
    w0 = wr_log_a.size(); d0 = done_cnt; b0 = busy_cnt;
    model_copy(16'h0000, 16'hC000, 4);
    do_start(16'h0000, 16'hC000, 4);
    wait_done("basic", d0, 100);
    check_eq("basic_done_lat", done_cyc - s_cyc, 13);
    check_eq("basic_busy_cycles", busy_cnt - b0, 12);
    check_eq("basic_done_pulses", done_cnt - d0, 1);
    check_writes("basic", w0);
    @(negedge clk);
    check_eq("basic_done_width", done, 1'b0);
    check_eq("basic_busy_after", busy, 1'b0);
    tick(1);

    // Zero-length transfer touches nothing on the bus.
    w0 = wr_log_a.size(); d0 = done_cnt; q0 = req_cnt; e0 = en_cnt; x0 = we_cnt;
    do_start(16'h1000, 16'h2000, 0);
    wait_done("zero", d0, 20);
    check_eq("zero_done_lat", done_cyc - s_cyc, 1);
    check_eq("zero_req", req_cnt - q0, 0);
    check_eq("zero_en", en_cnt - e0, 0);
    check_eq("zero_we", we_cnt - x0, 0);
    check_eq("zero_writes", wr_log_a.size() - w0, 0);

    // Misaligned start addresses, destination wraps past 0xFFFC.
    w0 = wr_log_a.size(); d0 = done_cnt; r0 = rd_log.size();
    model_copy(16'h0003, 16'hFFFE, 2);
    do_start(16'h0003, 16'hFFFE, 2);
    wait_done("wrap", d0, 100);
    check_eq("wrap_nreads", rd_log.size() - r0, 2);
    if (rd_log.size() - r0 >= 2) begin
      check_eq("wrap_raddr0", rd_log[r0], 16'h0000);
      check_eq("wrap_raddr1", rd_log[r0 + 1], 16'h0004);
    end
    check_writes("wrap", w0);

    // Grant withdrawn for 5 cycles in the WAIT of word 1.
    w0 = wr_log_a.size(); d0 = done_cnt; r0 = rd_log.size(); x0 = we_cnt;
    model_copy(16'h0100, 16'h0800, 3);
    do_start(16'h0100, 16'h0800, 3);
    tick(4);
    bus_grant = 1'b0;
    @(negedge clk);
    check_eq("drop_en_low", bus_enable, 1'b0);
    check_eq("drop_we_low", write_enable, 1'b0);
    check_eq("drop_req_high", bus_request, 1'b1);
    tick(5);
    bus_grant = 1'b1;
    wait_done("drop", d0, 100);
    check_eq("drop_nreads", rd_log.size() - r0, 4);
    if (rd_log.size() - r0 >= 4) begin
      check_eq("drop_reread1", rd_log[r0 + 2], 16'h0104);
      check_eq("drop_read2", rd_log[r0 + 3], 16'h0108);
    end
    check_eq("drop_we_strobes", we_cnt - x0, 3);
    check_writes("drop", w0);
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("drop_mem%0d", i), mem[(16'h0800 >> 2) + i], refm[(16'h0800 >> 2) + i]);

    // Reset during the write of word 2 of 4.
    w0 = wr_log_a.size(); d0 = done_cnt;
    do_start(16'h0200, 16'h0900, 4);
    tick(8);
    @(negedge clk);
    check_eq("rst_at_write", write_enable, 1'b1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_next");
    tick(20);
    check_eq("rst_no_done", done_cnt - d0, 0);
    nw = wr_log_a.size() - w0;
    check_eq("rst_partial_count", (nw == 2 || nw == 3), 1'b1);
    model_copy(16'h0200, 16'h0900, (nw < 2) ? 2 : nw);
    check_writes("rst", w0);

    // A second start while busy is ignored.
    w0 = wr_log_a.size(); d0 = done_cnt; r0 = rd_log.size();
    model_copy(16'h0300, 16'h0A00, 4);
    do_start(16'h0300, 16'h0A00, 4);
    tick(3);
    do_start(16'h0400, 16'h0B00, 2);
    s_cyc = s_cyc - 4;
    wait_done("busy_start", d0, 100);
    check_eq("busy_start_lat", done_cyc - s_cyc, 13);
    tick(20);
    check_eq("busy_start_dones", done_cnt - d0, 1);
    check_eq("busy_start_nreads", rd_log.size() - r0, 4);
    check_eq("busy_start_idle", busy, 1'b0);
    check_writes("busy_start", w0);

    // Random transfers with a randomly toggling grant.
    for (int t = 0; t < 8; t++) begin
      rs = 16'($urandom);
      rd = 16'($urandom);
      rn = $urandom_range(1, 12);
      w0 = wr_log_a.size(); d0 = done_cnt;
      model_copy(rs, rd, rn);
      bus_grant = 1'($urandom_range(0, 1));
      do_start(rs, rd, rn);
      k = 0;
      forever begin
        bus_grant = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (done_cnt != d0 || k >= 3000) break;
        k++;
        @(posedge clk);
        #1;
      end
      check_eq($sformatf("rand%0d_done", t), done_cnt - d0, 1);
      bus_grant = 1'b1;
      tick(1);
      check_writes($sformatf("rand%0d", t), w0);
    end

    bad = 0;
    for (int i = 0; i < 16384; i++) if (mem[i] !== refm[i]) bad++;
    check_eq("mem_image", bad, 0);
    check_eq("strobe_without_grant", nogrant_strobe, 0);
    check_eq("write_mask_bad", mask_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
